// File: rtl/modinv_helper_invert_precalc_param.sv
// Word-serial precalculation helper for the binary modular invertor.
//
// One run streams the multi-word operands r, s, u, v (LSW first) and produces
// 2r, 2s, r+s, u-v and v-u (pass A), then streams u, v and the freshly written
// u-v / v-u buffers back MSW first to produce u/2, v/2, (u-v)/2 and (v-u)/2
// (pass B). Comparison and carry flags are latched on the final pass-A write.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ena / rdy            start request (sampled only while idle) / idle flag
//   in_addr              shared read address of the r, s, u, v buffers
//   r_din..v_din         operand words, one-cycle synchronous read latency
//   diff_rd_addr         read address of the u-v / v-u buffers (pass B)
//   u_minus_v_din,
//   v_minus_u_din        read-back words of the difference buffers
//   wr_addr_a, wren_a    pass-A write port; r_dbl/s_dbl/r_plus_s/u_minus_v/
//                        v_minus_u data outputs
//   wr_addr_b, wren_b    pass-B write port; u_half/v_half/u_minus_v_half/
//                        v_minus_u_half data outputs
//   r_dbl_cy, s_dbl_cy,
//   r_plus_s_cy          bit shifted or carried out of the MSW
//   u_gt_v, u_eq_v       unsigned comparison of u and v
module modinv_helper_invert_precalc_param #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 9,
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    output logic                 rdy,
    output logic [ADDR_BITS-1:0] in_addr,
    input  logic [WORD_W-1:0]    r_din,
    input  logic [WORD_W-1:0]    s_din,
    input  logic [WORD_W-1:0]    u_din,
    input  logic [WORD_W-1:0]    v_din,
    output logic [ADDR_BITS-1:0] diff_rd_addr,
    input  logic [WORD_W-1:0]    u_minus_v_din,
    input  logic [WORD_W-1:0]    v_minus_u_din,
    output logic [ADDR_BITS-1:0] wr_addr_a,
    output logic                 wren_a,
    output logic [WORD_W-1:0]    r_dbl_dout,
    output logic [WORD_W-1:0]    s_dbl_dout,
    output logic [WORD_W-1:0]    r_plus_s_dout,
    output logic [WORD_W-1:0]    u_minus_v_dout,
    output logic [WORD_W-1:0]    v_minus_u_dout,
    output logic [ADDR_BITS-1:0] wr_addr_b,
    output logic                 wren_b,
    output logic [WORD_W-1:0]    u_half_dout,
    output logic [WORD_W-1:0]    v_half_dout,
    output logic [WORD_W-1:0]    u_minus_v_half_dout,
    output logic [WORD_W-1:0]    v_minus_u_half_dout,
    output logic                 r_dbl_cy,
    output logic                 s_dbl_cy,
    output logic                 r_plus_s_cy,
    output logic                 u_gt_v,
    output logic                 u_eq_v
);

    // r_cnt holds the cycle number within a run: 1..2N+2.
    localparam int unsigned CntW = $clog2(2 * NUM_WORDS + 3);

    localparam logic [CntW-1:0] CntOne      = CntW'(1);
    localparam logic [CntW-1:0] CntFirstWrA = CntW'(2);
    localparam logic [CntW-1:0] CntLastRdA  = CntW'(NUM_WORDS);
    localparam logic [CntW-1:0] CntLastA    = CntW'(NUM_WORDS + 1);
    localparam logic [CntW-1:0] CntFirstWrB = CntW'(NUM_WORDS + 3);
    localparam logic [CntW-1:0] CntLastRdB  = CntW'(2 * NUM_WORDS + 1);
    localparam logic [CntW-1:0] CntLast     = CntW'(2 * NUM_WORDS + 2);

    typedef enum logic [1:0] {
        StIdle,
        StPassA,
        StPassB
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_next;
    logic              w_start;

    logic              w_rd_a;
    logic              w_wr_a;
    logic              w_last_a;
    logic              w_rd_b;
    logic              w_wr_b;

    // Pass-A inter-word state.
    logic              r_r_shift;
    logic              r_s_shift;
    logic              r_carry;
    logic              r_bor_uv;
    logic              r_bor_vu;
    logic              r_uv_zero;

    // Pass-B inter-word state: bit 0 of the previously read (more significant) word.
    logic              r_u_lsb;
    logic              r_v_lsb;
    logic              r_uv_lsb;
    logic              r_vu_lsb;

    logic              r_r_dbl_cy;
    logic              r_s_dbl_cy;
    logic              r_r_plus_s_cy;
    logic              r_u_gt_v;
    logic              r_u_eq_v;

    logic [WORD_W:0]   w_sum;
    logic [WORD_W:0]   w_umv;
    logic [WORD_W:0]   w_vmu;
    logic              w_umv_zero;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_start      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (ena) begin
                    w_state_next = StPassA;
                    w_cnt_next   = CntOne;
                    w_start      = 1'b1;
                end
            end
            StPassA: begin
                w_cnt_next = r_cnt + CntOne;
                if (r_cnt == CntLastA) begin
                    w_state_next = StPassB;
                end
            end
            StPassB: begin
                if (r_cnt == CntLast) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CntOne;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign rdy      = (r_state == StIdle);
    assign w_rd_a   = (r_state == StPassA) && (r_cnt <= CntLastRdA);
    assign w_wr_a   = (r_state == StPassA) && (r_cnt >= CntFirstWrA);
    assign w_last_a = (r_state == StPassA) && (r_cnt == CntLastA);
    assign w_rd_b   = (r_state == StPassB) && (r_cnt <= CntLastRdB);
    assign w_wr_b   = (r_state == StPassB) && (r_cnt >= CntFirstWrB);

    // Addresses idle at 0; pass B walks MSW first.
    always_comb begin
        in_addr      = '0;
        diff_rd_addr = '0;
        wr_addr_a    = '0;
        wr_addr_b    = '0;
        if (w_rd_a) begin
            in_addr = ADDR_BITS'(r_cnt - CntOne);
        end
        if (w_rd_b) begin
            in_addr      = ADDR_BITS'(CntLastRdB - r_cnt);
            diff_rd_addr = ADDR_BITS'(CntLastRdB - r_cnt);
        end
        if (w_wr_a) begin
            wr_addr_a = ADDR_BITS'(r_cnt - CntFirstWrA);
        end
        if (w_wr_b) begin
            wr_addr_b = ADDR_BITS'(CntLast - r_cnt);
        end
    end

    // ------------------------------------------------------------------
    // Pass A datapath
    // ------------------------------------------------------------------
    // Bit WORD_W of each (WORD_W+1)-bit result is the carry (sum) or the
    // borrow (differences, set whenever the word result went negative).
    assign w_sum = {1'b0, r_din} + {1'b0, s_din} + (WORD_W + 1)'(r_carry);
    assign w_umv = {1'b0, u_din} - {1'b0, v_din} - (WORD_W + 1)'(r_bor_uv);
    assign w_vmu = {1'b0, v_din} - {1'b0, u_din} - (WORD_W + 1)'(r_bor_vu);
    assign w_umv_zero = (w_umv[WORD_W-1:0] == '0);

    assign wren_a         = w_wr_a;
    assign r_dbl_dout     = w_wr_a ? {r_din[WORD_W-2:0], r_r_shift} : '0;
    assign s_dbl_dout     = w_wr_a ? {s_din[WORD_W-2:0], r_s_shift} : '0;
    assign r_plus_s_dout  = w_wr_a ? w_sum[WORD_W-1:0] : '0;
    assign u_minus_v_dout = w_wr_a ? w_umv[WORD_W-1:0] : '0;
    assign v_minus_u_dout = w_wr_a ? w_vmu[WORD_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r_shift <= 1'b0;
            r_s_shift <= 1'b0;
            r_carry   <= 1'b0;
            r_bor_uv  <= 1'b0;
            r_bor_vu  <= 1'b0;
            r_uv_zero <= 1'b0;
        end else if (w_start) begin
            r_r_shift <= 1'b0;
            r_s_shift <= 1'b0;
            r_carry   <= 1'b0;
            r_bor_uv  <= 1'b0;
            r_bor_vu  <= 1'b0;
            r_uv_zero <= 1'b1;
        end else if (w_wr_a) begin
            r_r_shift <= r_din[WORD_W-1];
            r_s_shift <= s_din[WORD_W-1];
            r_carry   <= w_sum[WORD_W];
            r_bor_uv  <= w_umv[WORD_W];
            r_bor_vu  <= w_vmu[WORD_W];
            r_uv_zero <= r_uv_zero & w_umv_zero;
        end
    end

    // Flags are taken from the MSW as it is written, so no compare pass is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r_dbl_cy    <= 1'b0;
            r_s_dbl_cy    <= 1'b0;
            r_r_plus_s_cy <= 1'b0;
            r_u_gt_v      <= 1'b0;
            r_u_eq_v      <= 1'b0;
        end else if (w_last_a) begin
            r_r_dbl_cy    <= r_din[WORD_W-1];
            r_s_dbl_cy    <= s_din[WORD_W-1];
            r_r_plus_s_cy <= w_sum[WORD_W];
            r_u_gt_v      <= ~w_umv[WORD_W] & ~(r_uv_zero & w_umv_zero);
            r_u_eq_v      <= r_uv_zero & w_umv_zero;
        end
    end

    assign r_dbl_cy    = r_r_dbl_cy;
    assign s_dbl_cy    = r_s_dbl_cy;
    assign r_plus_s_cy = r_r_plus_s_cy;
    assign u_gt_v      = r_u_gt_v;
    assign u_eq_v      = r_u_eq_v;

    // ------------------------------------------------------------------
    // Pass B datapath
    // ------------------------------------------------------------------
    assign wren_b              = w_wr_b;
    assign u_half_dout         = w_wr_b ? {r_u_lsb, u_din[WORD_W-1:1]} : '0;
    assign v_half_dout         = w_wr_b ? {r_v_lsb, v_din[WORD_W-1:1]} : '0;
    assign u_minus_v_half_dout = w_wr_b ? {r_uv_lsb, u_minus_v_din[WORD_W-1:1]} : '0;
    assign v_minus_u_half_dout = w_wr_b ? {r_vu_lsb, v_minus_u_din[WORD_W-1:1]} : '0;

    // Cleared on the pass A -> B transition so the MSW shifts in a zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_u_lsb  <= 1'b0;
            r_v_lsb  <= 1'b0;
            r_uv_lsb <= 1'b0;
            r_vu_lsb <= 1'b0;
        end else if (w_last_a) begin
            r_u_lsb  <= 1'b0;
            r_v_lsb  <= 1'b0;
            r_uv_lsb <= 1'b0;
            r_vu_lsb <= 1'b0;
        end else if (w_wr_b) begin
            r_u_lsb  <= u_din[0];
            r_v_lsb  <= v_din[0];
            r_uv_lsb <= u_minus_v_din[0];
            r_vu_lsb <= v_minus_u_din[0];
        end
    end

endmodule

// File: tb/tb_modinv_helper_invert_precalc_param.sv
module tb_modinv_helper_invert_precalc_param;

    localparam int unsigned W   = 32;
    localparam int unsigned N   = 9;
    localparam int unsigned AB  = 4;
    localparam int unsigned TOT = W * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          rdy;
    logic [AB-1:0] in_addr;
    logic [W-1:0]  r_din, s_din, u_din, v_din;
    logic [AB-1:0] diff_rd_addr;
    logic [W-1:0]  u_minus_v_din, v_minus_u_din;
    logic [AB-1:0] wr_addr_a;
    logic          wren_a;
    logic [W-1:0]  r_dbl_dout, s_dbl_dout, r_plus_s_dout, u_minus_v_dout, v_minus_u_dout;
    logic [AB-1:0] wr_addr_b;
    logic          wren_b;
    logic [W-1:0]  u_half_dout, v_half_dout, u_minus_v_half_dout, v_minus_u_half_dout;
    logic          r_dbl_cy, s_dbl_cy, r_plus_s_cy, u_gt_v, u_eq_v;

    always #5 clk = ~clk;

    modinv_helper_invert_precalc_param #(
        .WORD_W   (W),
        .NUM_WORDS(N),
        .ADDR_BITS(AB)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ena                (ena),
        .rdy                (rdy),
        .in_addr            (in_addr),
        .r_din              (r_din),
        .s_din              (s_din),
        .u_din              (u_din),
        .v_din              (v_din),
        .diff_rd_addr       (diff_rd_addr),
        .u_minus_v_din      (u_minus_v_din),
        .v_minus_u_din      (v_minus_u_din),
        .wr_addr_a          (wr_addr_a),
        .wren_a             (wren_a),
        .r_dbl_dout         (r_dbl_dout),
        .s_dbl_dout         (s_dbl_dout),
        .r_plus_s_dout      (r_plus_s_dout),
        .u_minus_v_dout     (u_minus_v_dout),
        .v_minus_u_dout     (v_minus_u_dout),
        .wr_addr_b          (wr_addr_b),
        .wren_b             (wren_b),
        .u_half_dout        (u_half_dout),
        .v_half_dout        (v_half_dout),
        .u_minus_v_half_dout(u_minus_v_half_dout),
        .v_minus_u_half_dout(v_minus_u_half_dout),
        .r_dbl_cy           (r_dbl_cy),
        .s_dbl_cy           (s_dbl_cy),
        .r_plus_s_cy        (r_plus_s_cy),
        .u_gt_v             (u_gt_v),
        .u_eq_v             (u_eq_v)
    );

    // Buffer memories around the DUT (synchronous read, one-cycle latency).
    logic [W-1:0] r_mem [16];
    logic [W-1:0] s_mem [16];
    logic [W-1:0] u_mem [16];
    logic [W-1:0] v_mem [16];
    logic [W-1:0] umv_mem [16];
    logic [W-1:0] vmu_mem [16];

    always @(posedge clk) begin
        r_din         <= r_mem[in_addr];
        s_din         <= s_mem[in_addr];
        u_din         <= u_mem[in_addr];
        v_din         <= v_mem[in_addr];
        u_minus_v_din <= umv_mem[diff_rd_addr];
        v_minus_u_din <= vmu_mem[diff_rd_addr];
        if (wren_a) begin
            umv_mem[wr_addr_a] <= u_minus_v_dout;
            vmu_mem[wr_addr_a] <= v_minus_u_dout;
        end
    end

    typedef struct {
        logic [AB-1:0] addr;
        logic [W-1:0]  d0;
        logic [W-1:0]  d1;
        logic [W-1:0]  d2;
        logic [W-1:0]  d3;
    } wr_t;

    typedef struct {
        logic [AB-1:0] addr;
        logic [W-1:0]  d0;
        logic [W-1:0]  d1;
        logic [W-1:0]  d2;
        logic [W-1:0]  d3;
        logic [W-1:0]  d4;
    } wra_t;

    wra_t       qa[$];
    wr_t        qb[$];
    logic [4:0] qf[$];

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [4:0] last_flags = '0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-operand arithmetic on TOT-bit numbers.
    task automatic load_run(input logic [TOT-1:0] r, input logic [TOT-1:0] s,
                            input logic [TOT-1:0] u, input logic [TOT-1:0] v);
        logic [TOT:0]   sum;
        logic [TOT-1:0] rd, sd, umv, vmu, uh, vh, umvh, vmuh;
        wra_t           ea;
        wr_t            eb;
        sum  = {1'b0, r} + {1'b0, s};
        rd   = r << 1;
        sd   = s << 1;
        umv  = u - v;
        vmu  = v - u;
        uh   = u >> 1;
        vh   = v >> 1;
        umvh = umv >> 1;
        vmuh = vmu >> 1;
        for (int k = 0; k < N; k++) begin
            r_mem[k] = r[k*W +: W];
            s_mem[k] = s[k*W +: W];
            u_mem[k] = u[k*W +: W];
            v_mem[k] = v[k*W +: W];
            ea.addr = AB'(k);
            ea.d0   = rd[k*W +: W];
            ea.d1   = sd[k*W +: W];
            ea.d2   = sum[k*W +: W];
            ea.d3   = umv[k*W +: W];
            ea.d4   = vmu[k*W +: W];
            qa.push_back(ea);
        end
        for (int k = N - 1; k >= 0; k--) begin
            eb.addr = AB'(k);
            eb.d0   = uh[k*W +: W];
            eb.d1   = vh[k*W +: W];
            eb.d2   = umvh[k*W +: W];
            eb.d3   = vmuh[k*W +: W];
            qb.push_back(eb);
        end
        qf.push_back({r[TOT-1], s[TOT-1], sum[TOT], (u > v), (u == v)});
    endtask

    function automatic logic [TOT-1:0] rnd();
        logic [TOT-1:0] x;
        for (int k = 0; k < N; k++) x[k*W +: W] = $urandom;
        return x;
    endfunction

    // Monitor: schedule, idle levels, scoreboard pops and flag holding.
    always @(negedge clk) begin
        logic [4:0] fl;
        bit         ewa, ewb;
        int         ein, edf;
        wra_t       ea;
        wr_t        eb;
        if (mon_en) begin
            fl = {r_dbl_cy, s_dbl_cy, r_plus_s_cy, u_gt_v, u_eq_v};
            if (!rdy) begin
                cyc++;
            end else begin
                if (cyc != 0) chk("rdy_low_cycles", cyc, 2 * N + 2);
                cyc = 0;
            end
            ewa = (cyc >= 2) && (cyc <= N + 1);
            ewb = (cyc >= N + 3) && (cyc <= 2 * N + 2);
            ein = 0;
            edf = 0;
            if (cyc >= 1 && cyc <= N) begin
                ein = cyc - 1;
            end else if (cyc >= N + 2 && cyc <= 2 * N + 1) begin
                ein = 2 * N + 1 - cyc;
                edf = ein;
            end
            chk("wren_a", wren_a, ewa);
            chk("wren_b", wren_b, ewb);
            chk("in_addr", in_addr, ein);
            chk("diff_rd_addr", diff_rd_addr, edf);

            if (wren_a) begin
                if (qa.size() == 0) begin
                    chk("qa_underflow", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    chk("wr_addr_a", wr_addr_a, ea.addr);
                    chk("r_dbl", r_dbl_dout, ea.d0);
                    chk("s_dbl", s_dbl_dout, ea.d1);
                    chk("r_plus_s", r_plus_s_dout, ea.d2);
                    chk("u_minus_v", u_minus_v_dout, ea.d3);
                    chk("v_minus_u", v_minus_u_dout, ea.d4);
                end
            end else begin
                chk("idle_a", wr_addr_a | r_dbl_dout | s_dbl_dout | r_plus_s_dout
                    | u_minus_v_dout | v_minus_u_dout, 0);
            end

            if (wren_b) begin
                if (qb.size() == 0) begin
                    chk("qb_underflow", 1, 0);
                end else begin
                    eb = qb.pop_front();
                    chk("wr_addr_b", wr_addr_b, eb.addr);
                    chk("u_half", u_half_dout, eb.d0);
                    chk("v_half", v_half_dout, eb.d1);
                    chk("u_minus_v_half", u_minus_v_half_dout, eb.d2);
                    chk("v_minus_u_half", v_minus_u_half_dout, eb.d3);
                end
            end else begin
                chk("idle_b", wr_addr_b | u_half_dout | v_half_dout | u_minus_v_half_dout
                    | v_minus_u_half_dout, 0);
            end

            if (cyc == N + 2) begin
                if (qf.size() == 0) begin
                    chk("qf_underflow", 1, 0);
                end else begin
                    last_flags = qf.pop_front();
                    chk("flags", fl, last_flags);
                end
            end else begin
                chk("flags_hold", fl, last_flags);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (rdy !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (rdy !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_idle_timeout: actual rdy=%b required=1", rdy);
        end
    endtask

    task automatic run_one(input logic [TOT-1:0] r, input logic [TOT-1:0] s,
                           input logic [TOT-1:0] u, input logic [TOT-1:0] v, input bit toggle);
        wait_idle();
        @(posedge clk);
        #1;
        load_run(r, s, u, v);
        ena = 1'b1;
        @(posedge clk);
        #1;
        ena = 1'b0;
        if (toggle) begin
            repeat (17) begin
                ena = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            ena = 1'b0;
        end
        wait_idle();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rdy"}, rdy, 1);
        chk({tag, "_wren"}, {wren_a, wren_b}, 0);
        chk({tag, "_addr"}, {in_addr, diff_rd_addr, wr_addr_a, wr_addr_b}, 0);
        chk({tag, "_flags"}, {r_dbl_cy, s_dbl_cy, r_plus_s_cy, u_gt_v, u_eq_v}, 0);
        chk({tag, "_data"}, r_dbl_dout | s_dbl_dout | r_plus_s_dout | u_minus_v_dout
            | v_minus_u_dout | u_half_dout | v_half_dout | u_minus_v_half_dout
            | v_minus_u_half_dout, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TOT-1:0] a, b, c, d;
        rst_n = 1'b0;
        ena   = 1'b0;
        for (int k = 0; k < 16; k++) begin
            r_mem[k] = '0; s_mem[k] = '0; u_mem[k] = '0; v_mem[k] = '0;
            umv_mem[k] = '0; vmu_mem[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        @(posedge clk);
        #3 rst_n = 1'b1;
        mon_en = 1'b1;

        // Shifts across word boundaries, top bits set, u == v.
        a = '0; a[TOT-1] = 1'b1; a[W-1] = 1'b1; a[100] = 1'b1;
        c = rnd();
        run_one(a, '1, c, c, 1'b0);

        // Reset while idle clears the flags.
        @(posedge clk);
        #2 rst_n = 1'b0;
        last_flags = '0;
        #1 check_reset_state("idle_rst");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Carry ripples through every word; u < v with borrow ripple.
        a = TOT'(1);
        run_one(a, '1, TOT'(5), TOT'(7), 1'b0);
        // All zero.
        run_one('0, '0, '0, '0, 1'b0);
        // u = v + 1, u > v.
        d = rnd();
        d[TOT-1] = 1'b0;
        run_one(rnd(), rnd(), d + TOT'(1), d, 1'b0);
        // u differs from v only in the MSW.
        c = '0; c[TOT-1] = 1'b1;
        run_one(rnd(), rnd(), c, TOT'(1), 1'b0);
        run_one(rnd(), rnd(), TOT'(1), c, 1'b1);

        // Random runs, some with ena toggling mid-run.
        for (int i = 0; i < 8; i++) begin
            run_one(rnd(), rnd(), rnd(), rnd(), 1'(i % 2));
        end

        // ena held high: back-to-back runs with a single idle cycle.
        wait_idle();
        @(posedge clk);
        #1;
        load_run(rnd(), rnd(), rnd(), rnd());
        ena = 1'b1;
        @(posedge clk);
        #1;
        repeat (19) @(posedge clk);
        #1;
        load_run(rnd(), rnd(), rnd(), rnd());
        @(posedge clk);
        #1 chk("b2b_gap_rdy", rdy, 1);
        @(posedge clk);
        #1 chk("b2b_restart", rdy, 0);
        ena = 1'b0;
        wait_idle();

        // Reset asserted in cycle 15 (mid pass B).
        @(posedge clk);
        #1;
        load_run(rnd(), rnd(), rnd(), rnd());
        ena = 1'b1;
        @(posedge clk);
        #1 ena = 1'b0;
        repeat (14) @(posedge clk);
        #1 chk("pre_reset_wren_b", wren_b, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_rst_wren_b", wren_b, 0);
        chk("midrun_rst_rdy", rdy, 1);
        check_reset_state("midrun_rst");
        qa.delete();
        qb.delete();
        qf.delete();
        cyc = 0;
        last_flags = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);

        // A run after the aborted one behaves normally.
        run_one(rnd(), rnd(), rnd(), rnd(), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qf_drained", qf.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
